// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with an internal bit timer and a small transmit FIFO.
// Words enter through a valid/ready handshake and are sent LSB first as
// start / data / optional parity / 1-2 stop bits. Queued words go out back-to-back.
module uart_tx_fifo #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                              clk,
   input  logic                              resetn,
   input  logic [DATA_W-1:0]                 tx_data,
   input  logic                              tx_valid,
   output logic                              tx_ready,
   output logic                              tx_out,
   output logic                              busy,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam int IW = $clog2(DATA_W);

   localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] BIT_LAST   = IW'(DATA_W - 1);
   localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
   localparam logic          HAS_PARITY = (PARITY_EN != 0);
   localparam logic          ODD        = (PARITY_ODD != 0);
   localparam logic          STOP_LAST  = (STOP_BITS == 2);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

   state_e              state_q;
   logic [TW-1:0]       timer_q;
   logic [IW-1:0]       bitIdx_q;
   logic                stopIdx_q;
   logic [DATA_W-1:0]   shift_q;
   logic                parityBit_q;
   logic                txOut_q;
   logic                busy_q;

   logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
   logic [AW-1:0]       wrPtr_q, wrPtr_d;
   logic [AW-1:0]       rdPtr_q, rdPtr_d;
   logic [CW-1:0]       count_q, count_d;

   logic                push;
   logic                pop;
   logic                bitEnd;
   logic [DATA_W-1:0]   popData;

   assign tx_ready   = (count_q != FULL_COUNT);
   assign fifo_count = count_q;
   assign tx_out     = txOut_q;
   assign busy       = busy_q;
   assign push       = tx_valid && tx_ready;
   assign popData    = mem_q[rdPtr_q];

   // Decide when the FSM takes a word (idle, or the very last stop-bit cycle) and the FIFO next state.
   always_comb begin
      bitEnd  = (timer_q == TIMER_LAST);
      pop     = (count_q != '0) &&
                ((state_q == IDLE) || ((state_q == STOP) && bitEnd && (stopIdx_q == STOP_LAST)));
      wrPtr_d = push ? wrPtr_q + AW'(1) : wrPtr_q;
      rdPtr_d = pop  ? rdPtr_q + AW'(1) : rdPtr_q;
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // FIFO storage has no reset; stale contents are unreachable once the pointers are cleared.
   always_ff @(posedge clk) begin
      if (push) mem_q[wrPtr_q] <= tx_data;
   end

   // FIFO pointers and occupancy; reset discards anything queued.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
      end
   end

   // Frame sequencer; tx_out and busy are set on the transition into each state so they stay registered.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= IDLE;
         timer_q     <= '0;
         bitIdx_q    <= '0;
         stopIdx_q   <= 1'b0;
         shift_q     <= '0;
         parityBit_q <= 1'b0;
         txOut_q     <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pop) begin
                  shift_q     <= popData;
                  parityBit_q <= (^popData) ^ ODD;
                  state_q     <= START;
                  timer_q     <= '0;
                  txOut_q     <= 1'b0;
                  busy_q      <= 1'b1;
               end
            end
            START: begin
               if (bitEnd) begin
                  state_q  <= DATA;
                  timer_q  <= '0;
                  bitIdx_q <= '0;
                  txOut_q  <= shift_q[0];
               end else begin
                  timer_q <= timer_q + TW'(1);
               end
            end
            DATA: begin
               if (bitEnd) begin
                  timer_q <= '0;
                  if (bitIdx_q == BIT_LAST) begin
                     if (HAS_PARITY) begin
                        state_q <= PARITY;
                        txOut_q <= parityBit_q;
                     end else begin
                        state_q   <= STOP;
                        stopIdx_q <= 1'b0;
                        txOut_q   <= 1'b1;
                     end
                  end else begin
                     bitIdx_q <= bitIdx_q + IW'(1);
                     shift_q  <= shift_q >> 1;
                     txOut_q  <= shift_q[1];
                  end
               end else begin
                  timer_q <= timer_q + TW'(1);
               end
            end
            PARITY: begin
               if (bitEnd) begin
                  state_q   <= STOP;
                  timer_q   <= '0;
                  stopIdx_q <= 1'b0;
                  txOut_q   <= 1'b1;
               end else begin
                  timer_q <= timer_q + TW'(1);
               end
            end
            STOP: begin
               if (bitEnd) begin
                  timer_q <= '0;
                  if (stopIdx_q == STOP_LAST) begin
                     if (pop) begin
                        shift_q     <= popData;
                        parityBit_q <= (^popData) ^ ODD;
                        state_q     <= START;
                        txOut_q     <= 1'b0;
                     end else begin
                        state_q <= IDLE;
                        txOut_q <= 1'b1;
                        busy_q  <= 1'b0;
                     end
                  end else begin
                     stopIdx_q <= 1'b1;
                  end
               end else begin
                  timer_q <= timer_q + TW'(1);
               end
            end
            default: begin
               state_q <= IDLE;
               txOut_q <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three instances (plain, even parity, odd parity with two stop bits)
// share one stimulus stream and are compared every cycle against a frame-level reference model.
module tb_uart_tx_fifo;

   logic       clk;
   logic       rstN;
   logic       txValid;
   logic [7:0] txData;
   logic       txReadyV   [3];
   logic       txOutV     [3];
   logic       busyV      [3];
   logic [2:0] fifoCountV [3];

   int errors;
   int checks;

   // Reference model configuration per instance
   int cpbM   [3] = '{4, 4, 4};
   int parEnM [3] = '{0, 1, 1};
   int oddM   [3] = '{0, 0, 1};
   int stopM  [3] = '{1, 1, 2};

   // Reference model state: pending word queue, word on the line, cycle within its frame (-1 = idle)
   logic [7:0] mq   [3][8];
   int         head [3];
   int         cnt  [3];
   int         pos  [3];
   logic [7:0] cur  [3];

   uart_tx_fifo #(.CLKS_PER_BIT(4)) dutA (
      .clk(clk), .resetn(rstN), .tx_data(txData), .tx_valid(txValid),
      .tx_ready(txReadyV[0]), .tx_out(txOutV[0]), .busy(busyV[0]), .fifo_count(fifoCountV[0]));

   uart_tx_fifo #(.CLKS_PER_BIT(4), .PARITY_EN(1)) dutB (
      .clk(clk), .resetn(rstN), .tx_data(txData), .tx_valid(txValid),
      .tx_ready(txReadyV[1]), .tx_out(txOutV[1]), .busy(busyV[1]), .fifo_count(fifoCountV[1]));

   uart_tx_fifo #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dutC (
      .clk(clk), .resetn(rstN), .tx_data(txData), .tx_valid(txValid),
      .tx_ready(txReadyV[2]), .tx_out(txOutV[2]), .busy(busyV[2]), .fifo_count(fifoCountV[2]));

   // Free-running clock, period 10
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int frameLen(int i);
      return (1 + 8 + parEnM[i] + stopM[i]) * cpbM[i];
   endfunction

   // Line level for bit b of a frame carrying word w
   function automatic logic frameBit(int i, logic [7:0] w, int b);
      if (b == 0) return 1'b0;
      if (b <= 8) return w[b-1];
      if (parEnM[i] != 0 && b == 9) return (^w) ^ (oddM[i] != 0);
      return 1'b1;
   endfunction

   task automatic modelReset();
      for (int i = 0; i < 3; i++) begin
         head[i] = 0;
         cnt[i]  = 0;
         pos[i]  = -1;
         cur[i]  = 8'h00;
      end
   endtask

   // One clock edge: accept decided on the pre-edge queue size, frame advances, a new frame starts when the line frees
   task automatic modelStep(int i, logic valid, logic [7:0] data);
      logic acc;
      acc = valid && (cnt[i] != 4);
      if (pos[i] >= 0) begin
         pos[i]++;
         if (pos[i] == frameLen(i)) pos[i] = -1;
      end
      if (pos[i] < 0 && cnt[i] > 0) begin
         cur[i]  = mq[i][head[i]];
         head[i] = (head[i] + 1) % 8;
         cnt[i]--;
         pos[i]  = 0;
      end
      if (acc) begin
         mq[i][(head[i] + cnt[i]) % 8] = data;
         cnt[i]++;
      end
   endtask

   task automatic checkOutput();
      logic       expOut;
      logic       expBusy;
      logic       expReady;
      logic [2:0] expCnt;
      for (int i = 0; i < 3; i++) begin
         expOut   = (pos[i] < 0) ? 1'b1 : frameBit(i, cur[i], pos[i] / cpbM[i]);
         expBusy  = (pos[i] >= 0);
         expReady = (cnt[i] != 4);
         expCnt   = 3'(cnt[i]);
         checks++;
         assert (txOutV[i] === expOut) else begin
            errors++;
            $error("[TB] FAIL txOut[%0d] t=%0t: observed=%b expected=%b", i, $time, txOutV[i], expOut);
         end
         checks++;
         assert (busyV[i] === expBusy) else begin
            errors++;
            $error("[TB] FAIL busy[%0d] t=%0t: observed=%b expected=%b", i, $time, busyV[i], expBusy);
         end
         checks++;
         assert (txReadyV[i] === expReady) else begin
            errors++;
            $error("[TB] FAIL txReady[%0d] t=%0t: observed=%b expected=%b", i, $time, txReadyV[i], expReady);
         end
         checks++;
         assert (fifoCountV[i] === expCnt) else begin
            errors++;
            $error("[TB] FAIL fifoCount[%0d] t=%0t: observed=%0d expected=%0d", i, $time, fifoCountV[i], expCnt);
         end
      end
   endtask

   // Drive inputs at the falling edge, step the model on the rising edge, compare at the next falling edge
   task automatic applyStimulus(logic valid, logic [7:0] data, logic rst);
      rstN    = rst;
      txValid = valid;
      txData  = data;
      @(posedge clk);
      if (!rst) modelReset();
      else for (int i = 0; i < 3; i++) modelStep(i, valid, data);
      @(negedge clk);
      checkOutput();
   endtask

   task automatic runIdle(int n, output int busyA, output int busyC);
      busyA = 0;
      busyC = 0;
      for (int k = 0; k < n; k++) begin
         applyStimulus(1'b0, 8'h00, 1'b1);
         if (busyV[0] === 1'b1) busyA++;
         if (busyV[2] === 1'b1) busyC++;
      end
   endtask

   // Directed sequence followed by a random traffic phase
   initial begin
      int  bA;
      int  bC;
      int  waitCycles;
      logic sawReady;
      errors  = 0;
      checks  = 0;
      rstN    = 1'b0;
      txValid = 1'b0;
      txData  = 8'h00;
      modelReset();
      @(negedge clk);

      $display("[TB] reset with random inputs");
      for (int k = 0; k < 5; k++) applyStimulus(1'($urandom), 8'($urandom), 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b1);

      $display("[TB] single frame 0xA5");
      applyStimulus(1'b1, 8'hA5, 1'b1);
      runIdle(60, bA, bC);
      checks++;
      assert (bA === 40) else begin
         errors++;
         $error("[TB] FAIL busyLenA: observed=%0d expected=40", bA);
      end

      $display("[TB] parity frames 0x07 and 0x00");
      applyStimulus(1'b1, 8'h07, 1'b1);
      runIdle(60, bA, bC);
      applyStimulus(1'b1, 8'h00, 1'b1);
      runIdle(60, bA, bC);

      $display("[TB] back-to-back fill and backpressure");
      applyStimulus(1'b1, 8'h11, 1'b1);
      applyStimulus(1'b1, 8'h22, 1'b1);
      applyStimulus(1'b1, 8'h33, 1'b1);
      applyStimulus(1'b1, 8'h44, 1'b1);
      applyStimulus(1'b1, 8'h55, 1'b1);
      checks++;
      assert (txReadyV[0] === 1'b0) else begin
         errors++;
         $error("[TB] FAIL fullReadyA: observed=%b expected=0", txReadyV[0]);
      end
      sawReady   = 1'b0;
      waitCycles = 0;
      while (!sawReady && waitCycles < 200) begin
         sawReady = (txReadyV[0] === 1'b1);
         applyStimulus(1'b1, 8'hEE, 1'b1);
         waitCycles++;
      end
      checks++;
      assert (sawReady === 1'b1) else begin
         errors++;
         $error("[TB] FAIL eeAcceptTimeout: observed=%b expected=1", sawReady);
      end
      runIdle(350, bA, bC);

      $display("[TB] reset mid-frame");
      applyStimulus(1'b1, 8'h01, 1'b1);
      applyStimulus(1'b1, 8'h02, 1'b1);
      applyStimulus(1'b1, 8'h03, 1'b1);
      runIdle(8, bA, bC);
      rstN = 1'b0;
      modelReset();
      #1;
      checkOutput();
      applyStimulus(1'b0, 8'h00, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b1);
      applyStimulus(1'b1, 8'h3C, 1'b1);
      runIdle(60, bA, bC);
      checks++;
      assert (bC === 48) else begin
         errors++;
         $error("[TB] FAIL busyLenC: observed=%0d expected=48", bC);
      end

      $display("[TB] random traffic");
      for (int k = 0; k < 400; k++) applyStimulus(($urandom_range(0, 3) == 0), 8'($urandom), 1'b1);
      runIdle(300, bA, bC);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
